// File: rtl/fetch_line_buffer_if.sv
// -----------------------------------------------------------------------------
// fetch_line_buffer_if
//
// Purpose: bundles the pipeline-side fetch handshake and the instruction
// memory line bus of fetch_line_buffer into one interface.
//
// Signals:
//   pc         fetch address (bits [3:2] word select, [MEM_ADDR_W-1:4] tag)
//   pc_valid   a fetch is requested this cycle
//   inv        invalidate held line / abort fill
//   inst       returned instruction (0 when inst_valid=0)
//   inst_valid inst belongs to pc this cycle
//   stall      pc_valid && !inst_valid
//   mem_addr   registered, 16-byte aligned line address
//   mem_qdata  128-bit line from memory (word 0 in [127:96])
//   mem_ready  mem_qdata valid for mem_addr
//
// Modports:
//   master  pipeline + memory model side (drives pc, inv, memory response)
//   slave   the line buffer itself
// -----------------------------------------------------------------------------
interface fetch_line_buffer_if #(
  parameter int MEM_ADDR_W = 32
);
  logic [MEM_ADDR_W-1:0] pc;
  logic                  pc_valid;
  logic                  inv;
  logic [31:0]           inst;
  logic                  inst_valid;
  logic                  stall;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [127:0]          mem_qdata;
  logic                  mem_ready;

  modport master (
    output pc, pc_valid, inv, mem_qdata, mem_ready,
    input  inst, inst_valid, stall, mem_addr
  );

  modport slave (
    input  pc, pc_valid, inv, mem_qdata, mem_ready,
    output inst, inst_valid, stall, mem_addr
  );
endinterface

// File: rtl/fetch_line_buffer.sv
// -----------------------------------------------------------------------------
// fetch_line_buffer
//
// Purpose: single-line instruction buffer between the PC stage and the
// instruction memory. Holds one 128-bit line (four 32-bit words). A PC that
// hits the held line is answered combinationally in the same cycle; a miss
// stalls the pipeline while the line is fetched with a simple address/ready
// handshake, then the buffer resumes answering.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   bus         fetch_line_buffer_if.slave (pc/inst handshake + memory bus)
//   hit_count   cycles with inst_valid=1 (saturating)
//   miss_count  entries into ISSUE (saturating)
//
// Build option:
//   FETCH_PERF_EN  when defined, builds the two saturating performance
//                  counters; otherwise both counter ports read 0.
// -----------------------------------------------------------------------------
module fetch_line_buffer #(
  parameter int MEM_ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_line_buffer_if.slave   bus,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
);

  localparam int TAG_W = MEM_ADDR_W - 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HIT   = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [127:0]          line_q, line_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic                  line_valid_q, line_valid_d;
  logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic [TAG_W-1:0]      pc_tag;
  logic                  tag_match;
  logic                  hit;
  logic [31:0]           line_word [4];

  // Byte offset bits of pc carry no information for a word fetch.
  logic unused_pc_bits;
  assign unused_pc_bits = ^bus.pc[1:0];

  // Word 0 sits in the most significant slice of the line.
  for (genvar gi = 0; gi < 4; gi++) begin : g_word
    assign line_word[gi] = line_q[127 - 32*gi -: 32];
  end

  assign pc_tag    = bus.pc[MEM_ADDR_W-1:4];
  assign tag_match = (pc_tag == tag_q);

  // Only the HIT state answers; during ISSUE/WAIT the held line may be stale
  // relative to the fill in flight, so nothing is returned.
  assign hit = bus.pc_valid && line_valid_q && (state_q == S_HIT) && tag_match;

  assign bus.inst       = hit ? line_word[bus.pc[3:2]] : 32'h0;
  assign bus.inst_valid = hit;
  assign bus.stall      = bus.pc_valid && !hit;
  assign bus.mem_addr   = mem_addr_q;

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    tag_d        = tag_q;
    line_valid_d = line_valid_q;
    mem_addr_d   = mem_addr_q;

    if (bus.inv) begin
      // Invalidate wins over everything, including a capture this cycle.
      state_d      = S_IDLE;
      line_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.pc_valid) begin
            state_d    = S_ISSUE;
            mem_addr_d = {pc_tag, 4'b0000};
          end
        end
        S_HIT: begin
          if (bus.pc_valid && !tag_match) begin
            state_d    = S_ISSUE;
            mem_addr_d = {pc_tag, 4'b0000};
          end
        end
        S_ISSUE: begin
          // mem_ready here may still belong to the previous line request.
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (bus.mem_ready) begin
            state_d      = S_HIT;
            line_d       = bus.mem_qdata;
            tag_d        = mem_addr_q[MEM_ADDR_W-1:4];
            line_valid_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      line_q       <= '0;
      tag_q        <= '0;
      line_valid_q <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      tag_q        <= tag_d;
      line_valid_q <= line_valid_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef FETCH_PERF_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;
  logic        issue_entry;

  assign issue_entry = (state_d == S_ISSUE) && (state_q != S_ISSUE);

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (hit && (hit_count_q != 32'hFFFF_FFFF)) begin
      hit_count_d = hit_count_q + 32'd1;
    end
    if (issue_entry && (miss_count_q != 32'hFFFF_FFFF)) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = 32'h0;
  assign miss_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_line_buffer.sv
// -----------------------------------------------------------------------------
// tb_fetch_line_buffer
//
// Directed bench for fetch_line_buffer: cold miss timing, sequential hits,
// ready-during-ISSUE rejection, invalidate vs. capture, asynchronous reset
// mid-fill, idle HIT behaviour and the optional performance counters.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_line_buffer;

  logic clk;
  logic rst;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks;
  int errors;

  fetch_line_buffer_if #(.MEM_ADDR_W(32)) bus_if ();

  fetch_line_buffer #(.MEM_ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] LINE_A = 128'h10000001_20000002_30000003_40000004;
  localparam logic [127:0] LINE_B = 128'hB0B0_0000_B1B1_1111_B2B2_2222_B3B3_3333;
  localparam logic [127:0] LINE_C = 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3;
  localparam logic [127:0] LINE_D = 128'hD0000000_D1111111_D2222222_D3333333;
  localparam logic [127:0] DEAD   = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

  // Hand-written word values of LINE_A, word 0 first.
  logic [31:0] exp_a [4];
  logic [31:0] exp_hits;
  logic [31:0] exp_misses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %-16s got=%08h expected=%08h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %-16s = %08h", tag, got);
    end
  endtask

  // Inputs change 2ns after the rising edge; checks follow 1ns later.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_a[0] = 32'h10000001;
    exp_a[1] = 32'h20000002;
    exp_a[2] = 32'h30000003;
    exp_a[3] = 32'h40000004;

    rst              = 1'b1;
    bus_if.pc        = '0;
    bus_if.pc_valid  = 1'b0;
    bus_if.inv       = 1'b0;
    bus_if.mem_qdata = '0;
    bus_if.mem_ready = 1'b0;

    // ---------------- reset state ----------------
    #3;
    check("rst_inst_valid", {31'b0, bus_if.inst_valid}, 32'd0);
    check("rst_inst", bus_if.inst, 32'd0);
    check("rst_stall", {31'b0, bus_if.stall}, 32'd0);
    check("rst_mem_addr", bus_if.mem_addr, 32'd0);
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // ---------------- cold miss ----------------
    next_cycle();                                    // cycle 0
    bus_if.pc       = 32'h0040_0000;
    bus_if.pc_valid = 1'b1;
    #1;
    check("c0_stall", {31'b0, bus_if.stall}, 32'd1);
    check("c0_inst_valid", {31'b0, bus_if.inst_valid}, 32'd0);
    next_cycle(); #1;                                // cycle 1: ISSUE
    check("c1_mem_addr", bus_if.mem_addr, 32'h0040_0000);
    check("c1_stall", {31'b0, bus_if.stall}, 32'd1);
    next_cycle(); #1;                                // cycle 2: WAIT
    check("c2_stall", {31'b0, bus_if.stall}, 32'd1);
    next_cycle();                                    // cycle 3: memory answers
    bus_if.mem_ready = 1'b1;
    bus_if.mem_qdata = LINE_A;
    #1;
    check("c3_stall", {31'b0, bus_if.stall}, 32'd1);
    next_cycle();                                    // cycle 4: captured
    bus_if.mem_ready = 1'b0;
    bus_if.mem_qdata = '0;
    #1;
    check("c4_inst_valid", {31'b0, bus_if.inst_valid}, 32'd1);
    check("c4_inst", bus_if.inst, exp_a[0]);
    check("c4_stall", {31'b0, bus_if.stall}, 32'd0);

    // ---------------- sequential hits ----------------
    for (int i = 1; i < 4; i++) begin
      next_cycle();
      bus_if.pc = 32'h0040_0000 + 32'(4 * i);
      #1;
      check($sformatf("seq_inst_w%0d", i), bus_if.inst, exp_a[i]);
      check($sformatf("seq_stall_w%0d", i), {31'b0, bus_if.stall}, 32'd0);
    end

    // ---------------- counters after 1 miss + 4 hit cycles ----------------
    next_cycle();
`ifdef FETCH_PERF_EN
    exp_hits   = 32'd4;
    exp_misses = 32'd1;
`else
    exp_hits   = 32'd0;
    exp_misses = 32'd0;
`endif
    check("perf_hit_count", hit_count, exp_hits);
    check("perf_miss_count", miss_count, exp_misses);

    // ---------------- boundary crossing, ready during ISSUE ----------------
    bus_if.pc = 32'h0040_0010;
    #1;
    check("x_stall", {31'b0, bus_if.stall}, 32'd1);
    check("x_inst_valid", {31'b0, bus_if.inst_valid}, 32'd0);
    next_cycle();                                    // ISSUE, stale ready high
    bus_if.mem_ready = 1'b1;
    bus_if.mem_qdata = DEAD;
    #1;
    check("x_mem_addr", bus_if.mem_addr, 32'h0040_0010);
    next_cycle();                                    // WAIT, must not have captured
    bus_if.mem_ready = 1'b0;
    bus_if.mem_qdata = '0;
    #1;
    check("x_no_cap_valid", {31'b0, bus_if.inst_valid}, 32'd0);
    check("x_no_cap_stall", {31'b0, bus_if.stall}, 32'd1);
    next_cycle();
    bus_if.mem_ready = 1'b1;
    bus_if.mem_qdata = LINE_B;
    next_cycle();
    bus_if.mem_ready = 1'b0;
    bus_if.mem_qdata = '0;
    #1;
    check("x_inst_valid", {31'b0, bus_if.inst_valid}, 32'd1);
    check("x_inst", bus_if.inst, 32'hB0B0_0000);

    // ---------------- inv beats capture in WAIT ----------------
    next_cycle();
    bus_if.pc = 32'h0040_0020;
    next_cycle(); #1;                                // ISSUE
    check("inv_mem_addr", bus_if.mem_addr, 32'h0040_0020);
    next_cycle();                                    // WAIT
    bus_if.mem_ready = 1'b1;
    bus_if.mem_qdata = LINE_C;
    bus_if.inv       = 1'b1;
    next_cycle();                                    // IDLE
    bus_if.mem_ready = 1'b0;
    bus_if.mem_qdata = '0;
    bus_if.inv       = 1'b0;
    #1;
    check("inv_inst_valid", {31'b0, bus_if.inst_valid}, 32'd0);
    check("inv_stall", {31'b0, bus_if.stall}, 32'd1);
    bus_if.pc = 32'h0040_0034;
    next_cycle(); #1;                                // fresh ISSUE
    check("inv_fresh_addr", bus_if.mem_addr, 32'h0040_0030);

    // ---------------- async reset mid-WAIT ----------------
    next_cycle();                                    // WAIT
    #1;
    rst = 1'b1;
    #1;
    check("arst_inst_valid", {31'b0, bus_if.inst_valid}, 32'd0);
    check("arst_inst", bus_if.inst, 32'd0);
    check("arst_stall", {31'b0, bus_if.stall}, 32'd1);
    check("arst_mem_addr", bus_if.mem_addr, 32'd0);
    check("arst_hit_count", hit_count, 32'd0);
    check("arst_miss_count", miss_count, 32'd0);
    next_cycle();
    rst = 1'b0;
    bus_if.pc = 32'h0040_0030;
    #1;
    check("post_rst_stall", {31'b0, bus_if.stall}, 32'd1);
    next_cycle(); #1;                                // ISSUE
    check("post_rst_addr", bus_if.mem_addr, 32'h0040_0030);
    next_cycle();                                    // WAIT
    bus_if.mem_ready = 1'b1;
    bus_if.mem_qdata = LINE_D;
    next_cycle();                                    // HIT
    bus_if.mem_ready = 1'b0;
    bus_if.mem_qdata = '0;
    bus_if.pc        = 32'h0040_003C;
    #1;
    check("post_rst_inst", bus_if.inst, 32'hD3333333);

    // ---------------- no fetch in HIT ----------------
    bus_if.pc_valid = 1'b0;
    #1;
    check("idle_stall", {31'b0, bus_if.stall}, 32'd0);
    check("idle_inst_valid", {31'b0, bus_if.inst_valid}, 32'd0);
    check("idle_inst", bus_if.inst, 32'd0);
    next_cycle();
    next_cycle();
    bus_if.pc       = 32'h0040_0030;
    bus_if.pc_valid = 1'b1;
    #1;
    check("idle_held_addr", bus_if.mem_addr, 32'h0040_0030);
    check("idle_held_inst", bus_if.inst, 32'hD0000000);

    // ---------------- inv while in HIT ----------------
    bus_if.inv = 1'b1;
    next_cycle();
    bus_if.inv = 1'b0;
    #1;
    check("hinv_inst_valid", {31'b0, bus_if.inst_valid}, 32'd0);
    check("hinv_stall", {31'b0, bus_if.stall}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
